// File: rtl/abr_params_pkg.sv
// Shared memory-port types for the ML-DSA accelerator datapath.
package abr_params_pkg;

  localparam int ABR_MEM_ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10
  } mem_rw_mode_e;

  typedef struct packed {
    mem_rw_mode_e                  rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;

endpackage

// File: rtl/sigencode_h_defines_pkg.sv
// Constants, state encoding and lane priority encoder for the hint encoder.
package sigencode_h_defines_pkg;

  localparam int MLDSA_N            = 256;
  localparam int MLDSA_K            = 8;
  localparam int MLDSA_OMEGA        = 75;
  localparam int SGE_WORDS_PER_POLY = MLDSA_N / 4;
  localparam int SGE_COEFF_W        = 24;
  localparam int SGE_POLY_W         = $clog2(MLDSA_K);
  localparam int SGE_WORD_W         = $clog2(SGE_WORDS_PER_POLY);

  typedef enum logic [2:0] {
    SGE_IDLE,
    SGE_RD_REQ,
    SGE_RD_CAP,
    SGE_EMIT,
    SGE_PAD,
    SGE_SUM,
    SGE_DONE
  } sge_state_e;

  // Index of the lowest set bit; callers only use it when mask is non-zero.
  function automatic logic [1:0] sge_lowest_lane(input logic [3:0] mask);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lane = 2'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/sigencode_h.sv
// ML-DSA hint encoder: reads K hint polys (2 cycles/word + 1/hint) and streams indices, zero pad, hint sums.
// Byte stream is valid/ready; byte and last hold while stalled and no memory reads are issued meanwhile.
module sigencode_h
  import abr_params_pkg::*;
  import sigencode_h_defines_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          zeroize,
  input  logic                          sigencode_h_enable,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0] src_base_addr,
  output mem_if_t                       mem_rd_req,
  input  logic [4*SGE_COEFF_W-1:0]      mem_rd_data,
  output logic [7:0]                    enc_byte_o,
  output logic                          enc_valid_o,
  input  logic                          enc_ready_i,
  output logic                          enc_last_o,
  output logic                          sigencode_h_done,
  output logic                          sigencode_h_error
);

  localparam logic [7:0]            OMEGA_CNT = 8'(MLDSA_OMEGA);
  localparam logic [SGE_WORD_W-1:0] LAST_WORD = SGE_WORD_W'(SGE_WORDS_PER_POLY - 1);
  localparam logic [SGE_POLY_W-1:0] LAST_POLY = SGE_POLY_W'(MLDSA_K - 1);

  sge_state_e              state_q, state_d;
  logic [SGE_POLY_W-1:0]   poly_q, poly_d;
  logic [SGE_WORD_W-1:0]   word_q, word_d;
  logic [3:0]              mask_q, mask_d;
  logic [7:0]              hint_cnt_q, hint_cnt_d;
  logic [7:0]              byte_cnt_q, byte_cnt_d;
  logic [SGE_POLY_W-1:0]   sum_idx_q, sum_idx_d;
  logic                    error_q, error_d;
  logic [7:0]              hintsum_q [MLDSA_K];
  logic [7:0]              hintsum_d [MLDSA_K];

  logic [3:0] lane_bits;
  logic [1:0] lane;
  logic       advance;
  logic       unused_data_bits;

  // Only bit 0 of each 24-bit lane carries the hint.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_bits[i] = mem_rd_data[SGE_COEFF_W*i];
    end
  end
  assign unused_data_bits = ^mem_rd_data;

  always_comb begin
    state_d             = state_q;
    poly_d              = poly_q;
    word_d              = word_q;
    mask_d              = mask_q;
    hint_cnt_d          = hint_cnt_q;
    byte_cnt_d          = byte_cnt_q;
    sum_idx_d           = sum_idx_q;
    error_d             = error_q;
    hintsum_d           = hintsum_q;
    advance             = 1'b0;
    lane                = sge_lowest_lane(mask_q);
    mem_rd_req.rd_wr_en = RW_IDLE;
    mem_rd_req.addr     = '0;
    enc_valid_o         = 1'b0;
    enc_byte_o          = 8'h00;
    enc_last_o          = 1'b0;
    sigencode_h_done    = 1'b0;

    unique case (state_q)
      SGE_IDLE: begin
        if (sigencode_h_enable) begin
          poly_d     = '0;
          word_d     = '0;
          mask_d     = '0;
          hint_cnt_d = '0;
          byte_cnt_d = '0;
          sum_idx_d  = '0;
          error_d    = 1'b0;
          state_d    = SGE_RD_REQ;
        end
      end
      SGE_RD_REQ: begin
        mem_rd_req.rd_wr_en = RW_READ;
        mem_rd_req.addr     = src_base_addr + ABR_MEM_ADDR_WIDTH'({poly_q, word_q});
        state_d             = SGE_RD_CAP;
      end
      SGE_RD_CAP: begin
        mask_d = lane_bits;
        if (lane_bits != 4'b0000) state_d = SGE_EMIT;
        else                      advance = 1'b1;
      end
      SGE_EMIT: begin
        // A pending hint with the budget already spent is an overflow: abort silently.
        if (hint_cnt_q == OMEGA_CNT) begin
          error_d = 1'b1;
          state_d = SGE_DONE;
        end else begin
          enc_valid_o = 1'b1;
          enc_byte_o  = {word_q, lane};
          if (enc_ready_i) begin
            mask_d     = mask_q & ~(4'b0001 << lane);
            hint_cnt_d = hint_cnt_q + 8'd1;
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (mask_d == 4'b0000) advance = 1'b1;
          end
        end
      end
      SGE_PAD: begin
        enc_valid_o = 1'b1;
        if (enc_ready_i) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (byte_cnt_d == OMEGA_CNT) state_d = SGE_SUM;
        end
      end
      SGE_SUM: begin
        enc_valid_o = 1'b1;
        enc_byte_o  = hintsum_q[sum_idx_q];
        enc_last_o  = (sum_idx_q == LAST_POLY);
        if (enc_ready_i) begin
          if (sum_idx_q == LAST_POLY) state_d = SGE_DONE;
          else                        sum_idx_d = sum_idx_q + 1'b1;
        end
      end
      SGE_DONE: begin
        sigencode_h_done = 1'b1;
        state_d          = SGE_IDLE;
      end
      default: state_d = SGE_IDLE;
    endcase

    // Word/poly stepping shared by empty words and fully drained hint words.
    if (advance) begin
      if (word_q != LAST_WORD) begin
        word_d  = word_q + 1'b1;
        state_d = SGE_RD_REQ;
      end else begin
        hintsum_d[poly_q] = hint_cnt_d;
        word_d            = '0;
        if (poly_q != LAST_POLY) begin
          poly_d  = poly_q + 1'b1;
          state_d = SGE_RD_REQ;
        end else begin
          sum_idx_d = '0;
          state_d   = (byte_cnt_d == OMEGA_CNT) ? SGE_SUM : SGE_PAD;
        end
      end
    end

    if (zeroize) begin
      state_d    = SGE_IDLE;
      poly_d     = '0;
      word_d     = '0;
      mask_d     = '0;
      hint_cnt_d = '0;
      byte_cnt_d = '0;
      sum_idx_d  = '0;
      error_d    = 1'b0;
      for (int i = 0; i < MLDSA_K; i++) hintsum_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SGE_IDLE;
      poly_q     <= '0;
      word_q     <= '0;
      mask_q     <= '0;
      hint_cnt_q <= '0;
      byte_cnt_q <= '0;
      sum_idx_q  <= '0;
      error_q    <= 1'b0;
      for (int i = 0; i < MLDSA_K; i++) hintsum_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      poly_q     <= poly_d;
      word_q     <= word_d;
      mask_q     <= mask_d;
      hint_cnt_q <= hint_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sum_idx_q  <= sum_idx_d;
      error_q    <= error_d;
      hintsum_q  <= hintsum_d;
    end
  end

  assign sigencode_h_error = error_q;

endmodule

// File: tb/tb_sigencode_h.sv
// Randomized bench for sigencode_h: memory model, ready driver, byte-stream model and one compare process.
`timescale 1ns/1ps
module tb_sigencode_h;
  import abr_params_pkg::*;

  localparam int K     = 8;
  localparam int N     = 256;
  localparam int OMEGA = 75;

  logic                          clk;
  logic                          reset;
  logic                          zeroize;
  logic                          sigencode_h_enable;
  logic [ABR_MEM_ADDR_WIDTH-1:0] src_base_addr;
  mem_if_t                       mem_rd_req;
  logic [95:0]                   mem_rd_data;
  logic [7:0]                    enc_byte_o;
  logic                          enc_valid_o;
  logic                          enc_ready_i;
  logic                          enc_last_o;
  logic                          sigencode_h_done;
  logic                          sigencode_h_error;

  sigencode_h dut (
    .clk                (clk),
    .reset              (reset),
    .zeroize            (zeroize),
    .sigencode_h_enable (sigencode_h_enable),
    .src_base_addr      (src_base_addr),
    .mem_rd_req         (mem_rd_req),
    .mem_rd_data        (mem_rd_data),
    .enc_byte_o         (enc_byte_o),
    .enc_valid_o        (enc_valid_o),
    .enc_ready_i        (enc_ready_i),
    .enc_last_o         (enc_last_o),
    .sigencode_h_done   (sigencode_h_done),
    .sigencode_h_error  (sigencode_h_error)
  );

  int         total = 0;
  int         bad   = 0;
  bit         hmem [K][N];
  int         base;
  logic [8:0] exp_q [$];
  int         exp_err, exp_words, exp_done_cyc;
  int         cyc, start_cyc;
  bit         mon_en;
  int         rd_cnt, done_cnt, done_cyc, stall_n;
  int         ready_mode;
  bit         stall_done;
  int         stall_left;
  bit         prev_stall;
  logic [7:0] prev_byte;
  logic       prev_last;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [95:0] mem_word(input int w);
    logic [95:0] d;
    d = {$urandom, $urandom, $urandom};
    if (w >= 0 && w < 512)
      for (int i = 0; i < 4; i++) d[24*i] = hmem[w/64][(w%64)*4+i];
    return d;
  endfunction

  // One-cycle-latency memory; the request is sampled mid-cycle, data lands on the next edge.
  initial begin
    bit pend;
    int paddr;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      pend  = (mem_rd_req.rd_wr_en == RW_READ);
      paddr = int'(mem_rd_req.addr);
      @(posedge clk);
      if (pend) mem_rd_data <= mem_word(paddr - base);
      else      mem_rd_data <= {$urandom, $urandom, $urandom};
    end
  end

  initial begin
    enc_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        enc_ready_i = 1'b0;
      end else if (ready_mode == 2 && !stall_done && enc_valid_o && enc_byte_o == 8'h05) begin
        stall_done  = 1'b1;
        stall_left  = 9;
        enc_ready_i = 1'b0;
      end else if (ready_mode == 1) begin
        enc_ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        enc_ready_i = 1'b1;
      end
    end
  end

  // Compare process: reads, byte stream, stability under stall, done pulses.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_rd_req.rd_wr_en == RW_READ) begin
          chk("rd_addr", int'(mem_rd_req.addr), base + rd_cnt);
          chk("rd_while_valid", int'(enc_valid_o), 0);
          if (rd_cnt == 0) chk("rd_first_cyc", cyc - start_cyc, 0);
          rd_cnt++;
        end
        if (enc_valid_o) begin
          if (prev_stall) begin
            chk("hold_byte", int'(enc_byte_o), int'(prev_byte));
            chk("hold_last", int'(enc_last_o), int'(prev_last));
          end
          if (!enc_ready_i && enc_byte_o == 8'h05) stall_n++;
          if (enc_ready_i) begin
            if (exp_q.size() == 0) begin
              chk("extra_byte", int'(enc_byte_o), -1);
            end else begin
              e = exp_q.pop_front();
              chk("byte", int'(enc_byte_o), int'(e[7:0]));
              chk("last", int'(enc_last_o), int'(e[8]));
            end
          end
          prev_stall = !enc_ready_i;
          prev_byte  = enc_byte_o;
          prev_last  = enc_last_o;
        end else begin
          if (prev_stall) chk("valid_dropped", int'(enc_valid_o), 1);
          prev_stall = 1'b0;
        end
        if (sigencode_h_done) begin
          done_cnt++;
          done_cyc = cyc - start_cyc;
        end
      end
    end
  end

  task automatic clear_h();
    for (int p = 0; p < K; p++)
      for (int c = 0; c < N; c++) hmem[p][c] = 1'b0;
  endtask

  // Expected stream straight from the encoding rules.
  task automatic build_exp();
    int cnt;
    int sums [K];
    bit stop;
    exp_q.delete();
    cnt = 0; stop = 0; exp_words = 0; exp_err = 0;
    for (int p = 0; p < K; p++) begin
      for (int w = 0; w < 64; w++) begin
        if (!stop) begin
          exp_words++;
          for (int l = 0; l < 4; l++) begin
            if (!stop && hmem[p][w*4+l]) begin
              if (cnt == OMEGA) begin
                stop = 1; exp_err = 1;
              end else begin
                exp_q.push_back(9'(w*4+l));
                cnt++;
              end
            end
          end
        end
      end
      sums[p] = cnt;
    end
    if (exp_err == 0) begin
      while (exp_q.size() < OMEGA) exp_q.push_back(9'h000);
      for (int p = 0; p < K; p++) exp_q.push_back({(p == K-1), 8'(sums[p])});
    end
    exp_done_cyc = 2*exp_words + ((exp_err != 0) ? OMEGA + 1 : OMEGA + K);
  endtask

  task automatic run_case(input string name, input int mode, input int zbyte);
    int n;
    int dn;
    build_exp();
    base          = $urandom_range(0, 32767 - 512);
    src_base_addr = ABR_MEM_ADDR_WIDTH'(base);
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; stall_n = 0;
    stall_done = 0; stall_left = 0; prev_stall = 0; ready_mode = mode;
    @(posedge clk); #2;
    mon_en = 1'b1;
    sigencode_h_enable = 1'b1;
    @(posedge clk); #2;
    sigencode_h_enable = 1'b0;
    start_cyc = cyc;
    chk({name, ":err_clr"}, int'(sigencode_h_error), 0);
    if (zbyte >= 0) begin
      n = 0;
      while (!(enc_valid_o && enc_byte_o == 8'(zbyte)) && n < 3000) begin
        @(posedge clk); #2; n++;
      end
      chk({name, ":zero_trigger_seen"}, int'(n < 3000), 1);
      mon_en = 1'b0;
      zeroize = 1'b1;
      enc_ready_i = 1'b0;
      @(posedge clk); #2;
      zeroize = 1'b0;
      chk({name, ":zero_valid"}, int'(enc_valid_o), 0);
      dn = 0;
      repeat (5) begin
        @(negedge clk);
        if (sigencode_h_done || mem_rd_req.rd_wr_en == RW_READ || enc_valid_o) dn++;
      end
      chk({name, ":zero_quiet"}, dn, 0);
      chk({name, ":zero_err"}, int'(sigencode_h_error), 0);
    end else begin
      n = 0;
      while (done_cnt == 0 && n < 6000) begin
        @(posedge clk); #2; n++;
      end
      chk({name, ":done_seen"}, int'(done_cnt > 0), 1);
      if (mode != 1) chk({name, ":done_cyc"}, done_cyc, exp_done_cyc + ((mode == 2) ? 10 : 0));
      repeat (3) @(posedge clk);
      #2;
      chk({name, ":done_cnt"}, done_cnt, 1);
      chk({name, ":bytes_left"}, exp_q.size(), 0);
      chk({name, ":error"}, int'(sigencode_h_error), exp_err);
      chk({name, ":reads"}, rd_cnt, exp_words);
      chk({name, ":idle_valid"}, int'(enc_valid_o), 0);
      if (mode == 2) chk({name, ":stall_cycles"}, stall_n, 10);
      mon_en = 1'b0;
    end
  endtask

  task automatic set_sparse();
    clear_h();
    for (int c = 0; c < 4; c++) hmem[0][c] = 1'b1;
    hmem[7][255] = 1'b1;
  endtask

  task automatic set_75();
    clear_h();
    for (int c = 0; c < 75; c++) hmem[2][c] = 1'b1;
  endtask

  initial begin
    int nh;
    reset = 1'b1; zeroize = 1'b0; sigencode_h_enable = 1'b0;
    src_base_addr = '0; mon_en = 1'b0; ready_mode = 0; base = 0;
    stall_left = 0; stall_done = 1'b0; start_cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(enc_valid_o), 0);
    chk("rst_byte", int'(enc_byte_o), 0);
    chk("rst_last", int'(enc_last_o), 0);
    chk("rst_done", int'(sigencode_h_done), 0);
    chk("rst_error", int'(sigencode_h_error), 0);
    chk("rst_rw", int'(mem_rd_req.rd_wr_en), int'(RW_IDLE));
    chk("rst_addr", int'(mem_rd_req.addr), 0);
    @(posedge clk); #2;
    reset = 1'b0;

    set_sparse();
    build_exp();
    chk("model_sparse_len", exp_q.size(), 83);
    chk("model_sparse_b3", int'(exp_q[3]), 'h003);
    chk("model_sparse_b4", int'(exp_q[4]), 'h0FF);
    chk("model_sparse_b5", int'(exp_q[5]), 'h000);
    chk("model_sparse_sum0", int'(exp_q[75]), 'h004);
    chk("model_sparse_lastsum", int'(exp_q[82]), 'h105);
    chk("model_sparse_cyc", exp_done_cyc, 1107);
    run_case("sparse", 0, -1);

    clear_h();
    run_case("all_zero", 0, -1);

    set_75();
    build_exp();
    chk("model75_idx74", int'(exp_q[74]), 'h04A);
    chk("model75_sum1", int'(exp_q[76]), 'h000);
    chk("model75_sum2", int'(exp_q[77]), 'h04B);
    run_case("exact75", 0, -1);

    set_75();
    hmem[5][10] = 1'b1;
    build_exp();
    chk("model76_err", exp_err, 1);
    chk("model76_len", exp_q.size(), 75);
    chk("model76_words", exp_words, 5*64 + 3);
    run_case("over76", 0, -1);

    clear_h();
    run_case("after_err", 0, -1);

    set_sparse();
    hmem[0][5]   = 1'b1;
    hmem[3][100] = 1'b1;
    run_case("backpressure", 2, -1);

    set_sparse();
    run_case("zeroize", 0, 2);
    run_case("after_zeroize", 0, -1);

    for (int r = 0; r < 6; r++) begin
      clear_h();
      nh = $urandom_range(0, 95);
      for (int i = 0; i < nh; i++) hmem[$urandom_range(0, K-1)][$urandom_range(0, N-1)] = 1'b1;
      run_case($sformatf("rand%0d", r), (r % 2 == 0) ? 1 : 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sigencode_h.md
# sigencode_h

Hint-encoding controller for ML-DSA signature generation. It reads the K hint polynomials h[0..K-1] from coefficient memory, four coefficients per word. It emits the packed signature field as a byte stream: up to OMEGA hint indices, zero padding to OMEGA bytes, then K cumulative hint sums. It is the transmit-side counterpart of the signature hint decoder and feeds the signature register-API packer over a valid/ready byte interface.

## Interface
- MLDSA_N, 256, coefficients per polynomial (4 per memory word, 64 words/poly)
- MLDSA_K, 8, number of hint polynomials
- MLDSA_OMEGA, 75, maximum total hints
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- zeroize  in  1  synchronous clear of all state
- sigencode_h_enable  in  1  start pulse, sampled only in IDLE
- src_base_addr  in  ABR_MEM_ADDR_WIDTH  address of h[0] word 0
- mem_rd_req  out  mem_if_t  read request: addr and rd_wr_en (RW_READ or RW_IDLE)
- mem_rd_data  in  4*24  returned word; lane i (bits 24i+23:24i) is coefficient 4w+i; hint = bit 0 of the lane
- enc_byte_o  out  8  encoded byte
- enc_valid_o  out  1  byte valid
- enc_ready_i  in  1  consumer accepts byte
- enc_last_o  out  1  marks final byte (hintsum of poly K-1)
- sigencode_h_done  out  1  one-cycle pulse on completion or abort
- sigencode_h_error  out  1  sticky hint overflow (>OMEGA); cleared on next accepted enable

## Operation
- States: IDLE, RD_REQ, RD_CAP, EMIT, PAD, SUM, DONE.
- **IDLE**
  - On enable: clear poly, word, hint_cnt, byte_cnt and error → RD_REQ.
  - Enable in any other state is ignored.
- **RD_REQ**
  - Drives RW_READ at src_base_addr + poly*64 + word → RD_CAP.
- **RD_CAP**
  - Loads a 4-bit mask from lane bit 0.
  - Mask ≠ 0 → EMIT.
  - Mask = 0 → advance.
- **EMIT**
  - Presents the lowest set lane as index byte word*4+lane (0..255).
  - On handshake: clear that mask bit, hint_cnt+1, byte_cnt+1.
  - Mask empty after handshake → advance.
- **Advance**
  - Word < 63: word+1 → RD_REQ.
  - Word = 63: hintsum[poly] ← hint_cnt (8-bit register array, K entries).
  - Poly < K-1: poly+1, word=0 → RD_REQ.
  - Poly = K-1 → PAD (or SUM if byte_cnt = OMEGA).
- **PAD**
  - Emits 0x00 per handshake until byte_cnt = OMEGA → SUM.
- **SUM**
  - Emits hintsum[j] for j = 0..K-1.
  - enc_last_o with j = K-1; its handshake → DONE.
- **DONE**
  - Done pulse → IDLE.
- **Overflow**
  - In EMIT with mask ≠ 0 and hint_cnt = OMEGA: no byte is presented (valid stays low).
  - Error set → DONE; no padding or sums are emitted.
- hint_cnt is 8 bits; it cannot exceed OMEGA.
- Total bytes on success: exactly OMEGA+K.

## Timing
- **Reset values:** all outputs 0; mem_rd_req.rd_wr_en = RW_IDLE, addr = 0; state IDLE.
- **Start:** enable at cycle t → read issued at t+1.
- **Read latency:** fixed 1 cycle. Data is sampled in RD_CAP, the cycle after RD_REQ.
- **Cycles per word:**
  - No hints: 2 cycles.
  - Hint word: 2 + (number of hints), with no backpressure.
  - All-zero h: 1024 read cycles + OMEGA+K byte cycles + 1 DONE cycle.
- **Handshake:** transfer when enc_valid_o & enc_ready_i.
  - Byte and last stay stable while valid is high and ready is low.
  - No reads are issued while stalled.
- **Valid in EMIT/PAD/SUM:** high from state entry, and back-to-back across PAD→SUM.
- **zeroize:** next cycle state IDLE, valid 0, counters, mask, hintsums and error cleared, no done pulse. Overrides enable in the same cycle.
- **reset mid-operation:** same result as zeroize, immediately.
- **Done vs enable:** enable in the DONE cycle is ignored.

## Structure
- sigencode_h_defines_pkg: sge_state_e enum, SGE_WORDS_PER_POLY = MLDSA_N/4.
- mem_if_t and RW_* come from abr_params_pkg.
- Single module; no sub-module. The lowest-set-lane priority encoder is a package function.
- Expected size: about 250 lines of RTL.

## Test plan
- **All-zero h, ready = 1:**
  - 512 reads at base..base+511, in order.
  - 83 bytes of 0x00; enc_last on byte 82; one done pulse; error 0.
- **Sparse hints:** h[0] coeffs 0,1,2,3 and h[7] coeff 255 set.
  - Bytes 00 01 02 03 FF, then 70 × 00.
  - Then sums 04 04 04 04 04 04 04 05, last on 05.
- **Exactly 75 hints:** coeffs 0..74 of h[2].
  - Indices 0..74, then no pad bytes.
  - Sums 00 00 4B 4B 4B 4B 4B 4B.
- **76 hints:**
  - 75 indices accepted, then valid stays low.
  - error = 1, done pulse, then IDLE; a later enable clears error.
- **Backpressure:** ready low for 10 cycles while index 0x05 is presented.
  - Byte 0x05 held stable; no mem_rd_req reads during the stall.
  - Stream identical to the no-stall run.
- **zeroize mid-EMIT, then re-enable:**
  - valid 0 the next cycle; no done pulse.
  - The fresh run produces the full correct 83-byte stream.
